// File: rtl/uart_tx_if.sv
// Parallel-side bundle of the UART transmitter: payload request plus the serial line and busy flag.
// The master drives the request; the transmitter sits on the slave modport.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] i_p_data;
  logic                  i_data_valid;
  logic                  i_par_en;
  logic                  i_par_typ;
  logic                  o_tx_out;
  logic                  o_busy;

  modport master (
    output i_p_data, i_data_valid, i_par_en, i_par_typ,
    input  o_tx_out, o_busy
  );

  modport slave (
    input  i_p_data, i_data_valid, i_par_en, i_par_typ,
    output o_tx_out, o_busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one serial bit per i_clk cycle, start / LSB-first data / optional parity / stop.
// Outputs are registered, so the start bit appears the cycle after the accepting edge.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  uart_tx_if.slave     bus
);
  localparam int                CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  par_en_reg;
  logic                  par_reg;
  logic                  tx_reg;
  logic                  busy_reg;

  // state_reg names the bit currently on the line; tx_reg is loaded with the next bit at each edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      cnt_reg    <= '0;
      par_en_reg <= 1'b0;
      par_reg    <= 1'b0;
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.i_data_valid) begin
            shift_reg  <= bus.i_p_data;
            par_en_reg <= bus.i_par_en;
            par_reg    <= (^bus.i_p_data) ^ bus.i_par_typ;
            cnt_reg    <= '0;
            tx_reg     <= 1'b0;
            busy_reg   <= 1'b1;
            state_reg  <= START;
          end
        end
        START: begin
          tx_reg    <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
          state_reg <= DATA;
        end
        DATA: begin
          if (cnt_reg == LAST_IDX) begin
            cnt_reg <= '0;
            if (par_en_reg) begin
              tx_reg    <= par_reg;
              state_reg <= PARITY;
            end else begin
              tx_reg    <= 1'b1;
              state_reg <= STOP;
            end
          end else begin
            cnt_reg   <= cnt_reg + CNT_W'(1);
            tx_reg    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        PARITY: begin
          tx_reg    <= 1'b1;
          state_reg <= STOP;
        end
        STOP: begin
          // The cycle after the stop bit is a guaranteed idle-high cycle.
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_tx_out = tx_reg;
  assign bus.o_busy   = busy_reg;
endmodule

// File: tb/tb_uart_tx.sv
// Randomised and directed bench for uart_tx, checked every cycle against a queue-of-bits frame model.
// Directed frames additionally pin the model with hand-computed bit patterns.
module tb_uart_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx #(.DATA_WIDTH(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of line levels queued at acceptance.
  logic q[$];
  logic m_tx   = 1'b1;
  logic m_busy = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else if (q.size() > 0) begin
      m_tx   = q.pop_front();
      m_busy = 1'b1;
    end else if (m_busy) begin
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else if (bus.i_data_valid) begin
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(bus.i_p_data[i]);
      if (bus.i_par_en) q.push_back((^bus.i_p_data) ^ bus.i_par_typ);
      q.push_back(1'b1);
      $display("txn: accepted data=%02h par_en=%0d par_typ=%0d frame_len=%0d",
               bus.i_p_data, bus.i_par_en, bus.i_par_typ, q.size());
      m_tx   = q.pop_front();
      m_busy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_cycle", 32'(bus.o_tx_out), 32'(m_tx));
      check("busy_cycle", 32'(bus.o_busy), 32'(m_busy));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.o_busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // Sends one frame, scrambles the inputs during it, and records the line from the start bit on.
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           output logic [15:0] bits, output int bc);
    int n;
    n = pe ? 11 : 10;
    wait_idle();
    bus.i_p_data = d; bus.i_par_en = pe; bus.i_par_typ = pt; bus.i_data_valid = 1'b1;
    @(negedge clk);
    bus.i_data_valid = 1'b0;
    bus.i_p_data = ~d; bus.i_par_en = ~pe; bus.i_par_typ = ~pt;
    bits = '0;
    bc = 0;
    for (int i = 0; i < n; i++) begin
      bits[i] = bus.o_tx_out;
      bc += int'(bus.o_busy);
      @(negedge clk);
    end
    check("trail_idle_tx", 32'(bus.o_tx_out), 32'd1);
    check("trail_idle_busy", 32'(bus.o_busy), 32'd0);
  endtask

  logic [15:0] bits;
  int          bc;
  logic        seq_tx[0:29];
  logic        seq_busy[0:29];
  logic [7:0]  d2;
  int          s2;

  initial begin
    bus.i_p_data = '0; bus.i_data_valid = 1'b0; bus.i_par_en = 1'b0; bus.i_par_typ = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(bus.o_tx_out), 32'd1);
    check("reset_busy", 32'(bus.o_busy), 32'd0);
    chk_en = 1'b1;
    rst_n = 1'b1;

    // Idle hold after reset.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_hold_tx", 32'(bus.o_tx_out), 32'd1);
      check("idle_hold_busy", 32'(bus.o_busy), 32'd0);
    end

    run_frame(8'hA5, 1'b0, 1'b0, bits, bc);
    check("a5_pattern", 32'(bits[9:0]), 32'h34A);
    check("a5_busy_len", 32'(bc), 32'd10);

    run_frame(8'h03, 1'b1, 1'b0, bits, bc);
    check("even03_parity", 32'(bits[9]), 32'd0);
    check("even03_stop", 32'(bits[10]), 32'd1);
    check("even03_busy_len", 32'(bc), 32'd11);
    check("even03_data", 32'(bits[8:1]), 32'h03);

    run_frame(8'h07, 1'b1, 1'b1, bits, bc);
    check("odd07_parity", 32'(bits[9]), 32'd0);
    run_frame(8'h06, 1'b1, 1'b1, bits, bc);
    check("odd06_parity", 32'(bits[9]), 32'd1);

    // Request held while busy, data switched to 0xFF from the third cycle.
    wait_idle();
    bus.i_p_data = 8'h11; bus.i_par_en = 1'b0; bus.i_par_typ = 1'b0; bus.i_data_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      seq_tx[i] = bus.o_tx_out;
      seq_busy[i] = bus.o_busy;
      if (i == 1) bus.i_p_data = 8'hFF;
      if (i == 12) bus.i_data_valid = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) d2[i] = seq_tx[i + 1];
    check("busy_req_first_data", 32'(d2), 32'h11);
    check("busy_req_first_stop", 32'(seq_tx[9]), 32'd1);
    s2 = -1;
    for (int i = 10; i < 19; i++) if (s2 < 0 && seq_busy[i]) s2 = i;
    if (s2 < 0) begin
      check("busy_req_second_found", 32'd0, 32'd1);
    end else begin
      check("busy_req_gap_ge1", 32'(s2 - 10 >= 1), 32'd1);
      check("busy_req_gap_idle_tx", 32'(seq_tx[10]), 32'd1);
      for (int i = 0; i < 8; i++) d2[i] = seq_tx[s2 + 1 + i];
      check("busy_req_second_data", 32'(d2), 32'hFF);
    end

    // Reset during data bit 4.
    wait_idle();
    bus.i_p_data = 8'h5A; bus.i_par_en = 1'b1; bus.i_par_typ = 1'b0; bus.i_data_valid = 1'b1;
    @(negedge clk);
    bus.i_data_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_tx", 32'(bus.o_tx_out), 32'd1);
    check("midrst_busy", 32'(bus.o_busy), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("midrst_no_resume", 32'({bus.o_tx_out, bus.o_busy}), 32'b10);
    end
    run_frame(8'h3C, 1'b1, 1'b1, bits, bc);
    check("after_rst_data", 32'(bits[8:1]), 32'h3C);
    check("after_rst_parity", 32'(bits[9]), 32'd1);
    check("after_rst_busy_len", 32'(bc), 32'd11);

    // Random traffic, input churn and occasional resets; checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        bus.i_p_data  = 8'($urandom);
        bus.i_par_en  = 1'($urandom);
        bus.i_par_typ = 1'($urandom);
      end
      bus.i_data_valid = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
    end
    rst_n = 1'b1;
    bus.i_data_valid = 1'b0;
    repeat (15) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
